// File: rtl/hf_mover_pkg.sv
// Shared types and constants for the block mover.
// Covers the FSM states, datapath widths, mode encodings and the ANCILL status word layout.
package hf_mover_pkg;
    localparam int ADDR_W   = 9;
    localparam int COUNT_W  = 6;
    localparam int DATA_W   = 32;
    localparam int ANCILL_W = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RX   = 2'b01;
    localparam logic [1:0] MODE_TX   = 2'b10;

    localparam int ANC_SECT_LSB = 23;
    localparam int ANC_TX_BIT   = 22;
    localparam int ANC_ADDR_LSB = 13;
    localparam int ANC_CNT_LSB  = 7;

    function automatic logic [ANCILL_W-1:0] pack_ancill(
        input logic [1:0]         sect,
        input logic               tx,
        input logic [ADDR_W-1:0]  addr,
        input logic [COUNT_W-1:0] cnt
    );
        logic [ANCILL_W-1:0] a;
        a = '0;
        a[ANC_SECT_LSB +: 2]       = sect;
        a[ANC_TX_BIT]              = tx;
        a[ANC_ADDR_LSB +: ADDR_W]  = addr;
        a[ANC_CNT_LSB +: COUNT_W]  = cnt;
        return a;
    endfunction
endpackage

// File: rtl/hf_skid2.sv
// Two-entry FIFO for buffer read data on its way to the TX device.
// A flush empties it in one cycle; ent0 is always the head.
module hf_skid2 import hf_mover_pkg::*; (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o
);
    logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]        occ_q, occ_d;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) ent0_d = push_data_i;
                    else               ent1_d = push_data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        ent0_d = ent1_q;
                        ent1_d = push_data_i;
                    end else begin
                        ent0_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = ent0_q;
    assign occ_o   = occ_q;
endmodule

// File: rtl/hf_block_mover.sv
// Moves a block of words between the packet buffer and a device port (RX or TX).
// Status (count, flags, ANCILL) is held from the end of a transfer until the next accepted issue.
module hf_block_mover import hf_mover_pkg::*; (
    input  logic                CLK,
    input  logic                RST,
    input  logic                BLCK_ISSUE,
    input  logic [ADDR_W-1:0]   BLCK_START,
    input  logic [COUNT_W-1:0]  BLCK_COUNT_REQ,
    input  logic [1:0]          BLCK_SECTION,
    input  logic [1:0]          MVBLCK_MODE,
    output logic                BLCK_WORKING,
    output logic [COUNT_W-1:0]  BLCK_COUNT_SENT,
    output logic                BLCK_IRQ,
    output logic                BLCK_ABRUPT_STOP,
    output logic                BLCK_FRDRAM_DEVERR,
    output logic [ANCILL_W-1:0] BLCK_ANCILL,
    output logic [ADDR_W-1:0]   BUF_ADDR,
    output logic                BUF_RE,
    output logic                BUF_WE,
    output logic [DATA_W-1:0]   BUF_WDATA,
    input  logic [DATA_W-1:0]   BUF_RDATA,
    input  logic                RX_VALID,
    input  logic [DATA_W-1:0]   RX_DATA,
    input  logic                RX_EOP,
    output logic                RX_READY,
    output logic                TX_VALID,
    output logic [DATA_W-1:0]   TX_DATA,
    input  logic                TX_READY,
    input  logic                DEV_ABORT,
    input  logic                DEV_ERR
);
    state_e             state_q, state_d;
    logic [1:0]         mode_q, sect_q;
    logic [COUNT_W-1:0] req_q, cnt_q, rd_cnt_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               rd_pend_q, irq_q, abrt_q, deverr_q;

    logic               in_xfer, is_rx, is_tx, issue_ok, stop_req;
    logic               rx_ready, tx_valid, buf_re, working;
    logic               rx_fire, tx_fire, moved, last_word, eop_hit, done;
    logic               fifo_vld, fifo_push, fifo_flush, pop_est;
    logic [DATA_W-1:0]  fifo_data;
    logic [1:0]         fifo_occ;
    logic [2:0]         credit;

    assign in_xfer  = (state_q == ST_XFER);
    assign is_rx    = (mode_q == MODE_RX);
    assign is_tx    = (mode_q == MODE_TX);
    assign issue_ok = (state_q == ST_IDLE) & BLCK_ISSUE &
                      ((MVBLCK_MODE == MODE_RX) | (MVBLCK_MODE == MODE_TX));
    assign stop_req = in_xfer & (DEV_ABORT | DEV_ERR | (MVBLCK_MODE != mode_q));

    assign rx_fire   = rx_ready & RX_VALID;
    assign tx_fire   = tx_valid & TX_READY;
    assign moved     = rx_fire | tx_fire;
    assign last_word = moved & ((cnt_q + COUNT_W'(1)) == req_q);
    assign eop_hit   = rx_fire & RX_EOP;
    assign done      = last_word | eop_hit;

    // Occupancy net of this cycle's pop, so a read can be issued every cycle while the device drains.
    assign pop_est = fifo_vld & TX_READY;
    assign credit  = {1'b0, fifo_occ} - {2'b00, pop_est} + {2'b00, rd_pend_q};

    assign fifo_push  = rd_pend_q & in_xfer & ~stop_req;
    assign fifo_flush = ~in_xfer | stop_req;

    hf_skid2 u_txq (
        .CLK         (CLK),
        .RST         (RST),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (BUF_RDATA),
        .pop_i       (tx_fire),
        .valid_o     (fifo_vld),
        .data_o      (fifo_data),
        .occ_o       (fifo_occ)
    );

    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (issue_ok) state_d = (BLCK_COUNT_REQ == '0) ? ST_FLUSH : ST_XFER;
            ST_XFER: begin
                if (stop_req)  state_d = ST_FLUSH;
                else if (done) state_d = ST_IDLE;
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        working  = 1'b0;
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        buf_re   = 1'b0;
        case (state_q)
            ST_XFER: begin
                working  = 1'b1;
                rx_ready = is_rx & ~stop_req;
                tx_valid = is_tx & ~stop_req & fifo_vld;
                buf_re   = is_tx & ~stop_req & (rd_cnt_q < req_q) & (credit < 3'd2);
            end
            ST_FLUSH: working = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q    <= MODE_HALT;
            sect_q    <= 2'b00;
            req_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            rd_pend_q <= 1'b0;
            irq_q     <= 1'b0;
            abrt_q    <= 1'b0;
            deverr_q  <= 1'b0;
        end else begin
            rd_pend_q <= buf_re;
            if (issue_ok) begin
                mode_q   <= MVBLCK_MODE;
                sect_q   <= BLCK_SECTION;
                req_q    <= BLCK_COUNT_REQ;
                addr_q   <= BLCK_START;
                cnt_q    <= '0;
                rd_cnt_q <= '0;
                irq_q    <= 1'b0;
                abrt_q   <= 1'b0;
                deverr_q <= 1'b0;
            end else begin
                if (moved)            cnt_q    <= cnt_q + COUNT_W'(1);
                if (rx_fire | buf_re) addr_q   <= addr_q + ADDR_W'(1);
                if (buf_re)           rd_cnt_q <= rd_cnt_q + COUNT_W'(1);
                if (eop_hit)          irq_q    <= 1'b1;
                if (stop_req) begin
                    abrt_q   <= 1'b1;
                    deverr_q <= DEV_ERR;
                end
            end
        end
    end

    assign BLCK_WORKING       = working;
    assign BLCK_COUNT_SENT    = cnt_q;
    assign BLCK_IRQ           = irq_q;
    assign BLCK_ABRUPT_STOP   = abrt_q;
    assign BLCK_FRDRAM_DEVERR = deverr_q;
    assign BLCK_ANCILL        = pack_ancill(sect_q, mode_q[1], addr_q, req_q);
    assign BUF_ADDR           = addr_q;
    assign BUF_RE             = buf_re;
    assign BUF_WE             = rx_fire;
    assign BUF_WDATA          = rx_fire ? RX_DATA : '0;
    assign RX_READY           = rx_ready;
    assign TX_VALID           = tx_valid;
    assign TX_DATA            = tx_valid ? fifo_data : '0;
endmodule

// File: tb/tb_hf_block_mover.sv
// Directed bench for hf_block_mover: RX wrap, EOP, TX streaming/backpressure, errors, reset.
// A simple buffer model returns 0xA500_0000|addr one cycle after each read.
module tb_hf_block_mover;
    logic        CLK = 1'b0;
    logic        RST;
    logic        BLCK_ISSUE;
    logic [8:0]  BLCK_START;
    logic [5:0]  BLCK_COUNT_REQ;
    logic [1:0]  BLCK_SECTION;
    logic [1:0]  MVBLCK_MODE;
    logic        BLCK_WORKING;
    logic [5:0]  BLCK_COUNT_SENT;
    logic        BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR;
    logic [24:0] BLCK_ANCILL;
    logic [8:0]  BUF_ADDR;
    logic        BUF_RE, BUF_WE;
    logic [31:0] BUF_WDATA;
    logic [31:0] BUF_RDATA = 32'h0;
    logic        RX_VALID;
    logic [31:0] RX_DATA;
    logic        RX_EOP, RX_READY;
    logic        TX_VALID;
    logic [31:0] TX_DATA;
    logic        TX_READY, DEV_ABORT, DEV_ERR;

    hf_block_mover dut (
        .CLK(CLK), .RST(RST), .BLCK_ISSUE(BLCK_ISSUE), .BLCK_START(BLCK_START),
        .BLCK_COUNT_REQ(BLCK_COUNT_REQ), .BLCK_SECTION(BLCK_SECTION), .MVBLCK_MODE(MVBLCK_MODE),
        .BLCK_WORKING(BLCK_WORKING), .BLCK_COUNT_SENT(BLCK_COUNT_SENT), .BLCK_IRQ(BLCK_IRQ),
        .BLCK_ABRUPT_STOP(BLCK_ABRUPT_STOP), .BLCK_FRDRAM_DEVERR(BLCK_FRDRAM_DEVERR),
        .BLCK_ANCILL(BLCK_ANCILL), .BUF_ADDR(BUF_ADDR), .BUF_RE(BUF_RE), .BUF_WE(BUF_WE),
        .BUF_WDATA(BUF_WDATA), .BUF_RDATA(BUF_RDATA), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
        .RX_EOP(RX_EOP), .RX_READY(RX_READY), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
        .TX_READY(TX_READY), .DEV_ABORT(DEV_ABORT), .DEV_ERR(DEV_ERR)
    );

    always #5 CLK = ~CLK;

    localparam logic [31:0] RXBASE = 32'hD000_0000;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int wr_n = 0, tx_n = 0, re_n = 0;
    logic [8:0]  wr_a [64];
    logic [31:0] wr_d [64];
    logic [31:0] tx_d [64];
    int          tx_c [64];
    int wr_base, tx_base, re_base;
    int eop_at = -1, err_at = -1, drop_at = -1;
    bit tx_tog = 1'b0;
    int wcyc;

    function automatic logic [31:0] mem_val(input logic [8:0] a);
        return 32'hA500_0000 | {23'h0, a};
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (BUF_RE) BUF_RDATA <= mem_val(BUF_ADDR);

    always @(negedge CLK) begin
        if (BUF_WE && wr_n < 64) begin
            wr_a[wr_n] <= BUF_ADDR;
            wr_d[wr_n] <= BUF_WDATA;
            wr_n <= wr_n + 1;
        end
        if (BUF_RE) re_n <= re_n + 1;
        if (TX_VALID && TX_READY && tx_n < 64) begin
            tx_d[tx_n] <= TX_DATA;
            tx_c[tx_n] <= cyc;
            tx_n <= tx_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic mark();
        wr_base = wr_n; tx_base = tx_n; re_base = re_n;
    endtask

    task automatic issue(input logic [8:0] st, input logic [5:0] n,
                         input logic [1:0] sec, input logic [1:0] md);
        BLCK_START = st; BLCK_COUNT_REQ = n; BLCK_SECTION = sec; MVBLCK_MODE = md;
        BLCK_ISSUE = 1'b1;
        @(negedge CLK);
        chk("idle_at_issue", BLCK_WORKING, 1'b0);
        tick();
        BLCK_ISSUE = 1'b0;
    endtask

    // Drives the device side each cycle until WORKING drops; returns cycles WORKING was high.
    task automatic run(input int max_cyc, output int wc);
        int k, g, mv;
        bit acc;
        k = 0; wc = 0;
        RX_DATA = RXBASE; RX_EOP = (eop_at == 0);
        for (g = 0; g < max_cyc; g++) begin
            @(negedge CLK);
            if (!BLCK_WORKING) break;
            wc++;
            acc = RX_VALID && RX_READY;
            tick();
            if (acc) k++;
            RX_DATA = RXBASE + 32'(k);
            RX_EOP  = (k == eop_at);
            if (tx_tog) TX_READY = ~TX_READY;
            mv = (tx_n - tx_base) + (wr_n - wr_base);
            if (err_at >= 0 && mv >= err_at) DEV_ERR = 1'b1;
            if (drop_at >= 0 && mv >= drop_at) MVBLCK_MODE = 2'b00;
        end
        chk("run_timeout", (g < max_cyc), 1'b1);
    endtask

    initial begin
        RST = 1'b1; BLCK_ISSUE = 1'b1; BLCK_START = 9'h005; BLCK_COUNT_REQ = 6'd4;
        BLCK_SECTION = 2'b11; MVBLCK_MODE = 2'b01;
        RX_VALID = 1'b0; RX_DATA = 32'h0; RX_EOP = 1'b0;
        TX_READY = 1'b0; DEV_ABORT = 1'b0; DEV_ERR = 1'b0;
        repeat (3) @(posedge CLK); #1;

        // Reset state, with an issue held alongside reset
        @(negedge CLK);
        chk("rst_working", BLCK_WORKING, 1'b0);
        chk("rst_status", {BLCK_COUNT_SENT, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 32'h0);
        chk("rst_ancill", BLCK_ANCILL, 32'h0);
        chk("rst_strobes", {BUF_RE, BUF_WE, RX_READY, TX_VALID, BUF_ADDR}, 32'h0);
        tick();
        RST = 1'b0; BLCK_ISSUE = 1'b0; MVBLCK_MODE = 2'b00;
        @(negedge CLK);
        chk("rst_prio", BLCK_WORKING, 1'b0);
        tick();

        // RX with buffer address wrap
        mark(); RX_VALID = 1'b1;
        issue(9'h1FE, 6'd4, 2'b10, 2'b01);
        run(30, wcyc);
        RX_VALID = 1'b0;
        chk("rx_wcyc", wcyc, 4);
        chk("rx_nwr", wr_n - wr_base, 4);
        chk("rx_a0", wr_a[wr_base],   9'h1FE);
        chk("rx_a1", wr_a[wr_base+1], 9'h1FF);
        chk("rx_a2", wr_a[wr_base+2], 9'h000);
        chk("rx_a3", wr_a[wr_base+3], 9'h001);
        chk("rx_d0", wr_d[wr_base],   RXBASE);
        chk("rx_d3", wr_d[wr_base+3], RXBASE + 32'd3);
        chk("rx_cnt", BLCK_COUNT_SENT, 6'd4);
        chk("rx_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 3'b000);
        chk("rx_ancill", BLCK_ANCILL, {2'b10, 1'b0, 9'h002, 6'd4, 7'h00});
        tick();

        // RX ends early on EOP with the third word
        mark(); RX_VALID = 1'b1; eop_at = 2;
        issue(9'h040, 6'd10, 2'b01, 2'b01);
        run(30, wcyc);
        RX_VALID = 1'b0; RX_EOP = 1'b0; eop_at = -1;
        chk("eop_wcyc", wcyc, 3);
        chk("eop_nwr", wr_n - wr_base, 3);
        chk("eop_cnt", BLCK_COUNT_SENT, 6'd3);
        chk("eop_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 3'b100);
        chk("eop_ancill", BLCK_ANCILL, {2'b01, 1'b0, 9'h043, 6'd10, 7'h00});
        tick();

        // TX streaming at full rate
        mark(); TX_READY = 1'b1;
        issue(9'h010, 6'd8, 2'b01, 2'b10);
        run(40, wcyc);
        chk("tx_wcyc", wcyc, 10);
        chk("tx_nwords", tx_n - tx_base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("tx_d%0d", i), tx_d[tx_base+i], mem_val(9'h010 + 9'(i)));
        chk("tx_rate", tx_c[tx_base+7] - tx_c[tx_base], 7);
        chk("tx_nre", re_n - re_base, 8);
        chk("tx_cnt", BLCK_COUNT_SENT, 6'd8);
        chk("tx_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 3'b000);
        chk("tx_ancill", BLCK_ANCILL, {2'b01, 1'b1, 9'h018, 6'd8, 7'h00});
        tick();

        // TX with toggling backpressure across the address wrap
        mark(); TX_READY = 1'b1; tx_tog = 1'b1;
        issue(9'h1FC, 6'd8, 2'b00, 2'b10);
        run(60, wcyc);
        tx_tog = 1'b0; TX_READY = 1'b1;
        chk("bp_nwords", tx_n - tx_base, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_d%0d", i), tx_d[tx_base+i], mem_val(9'h1FC + 9'(i)));
        chk("bp_nre", re_n - re_base, 8);
        chk("bp_cnt", BLCK_COUNT_SENT, 6'd8);
        tick();

        // DEV_ERR after five TX words
        mark(); err_at = 5;
        issue(9'h020, 6'd10, 2'b11, 2'b10);
        run(40, wcyc);
        DEV_ERR = 1'b0; err_at = -1;
        chk("err_nwords", tx_n - tx_base, 5);
        chk("err_cnt", BLCK_COUNT_SENT, 6'd5);
        chk("err_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 3'b011);
        chk("err_wcyc", wcyc, 9);
        tick();

        // Mode dropped to halt mid RX transfer
        mark(); RX_VALID = 1'b1; drop_at = 2;
        issue(9'h080, 6'd10, 2'b00, 2'b01);
        run(30, wcyc);
        RX_VALID = 1'b0; drop_at = -1; MVBLCK_MODE = 2'b00;
        chk("drop_nwr", wr_n - wr_base, 2);
        chk("drop_cnt", BLCK_COUNT_SENT, 6'd2);
        chk("drop_flags", {BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 3'b010);
        chk("drop_wcyc", wcyc, 4);
        tick();

        // Reset in the middle of a TX transfer
        issue(9'h100, 6'd8, 2'b10, 2'b10);
        repeat (4) tick();
        @(negedge CLK);
        chk("mid_busy", BLCK_WORKING, 1'b1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0; MVBLCK_MODE = 2'b00;
        @(negedge CLK);
        chk("mrst_working", BLCK_WORKING, 1'b0);
        chk("mrst_status", {BLCK_COUNT_SENT, BLCK_IRQ, BLCK_ABRUPT_STOP, BLCK_FRDRAM_DEVERR}, 32'h0);
        chk("mrst_ancill", BLCK_ANCILL, 32'h0);
        chk("mrst_strobes", {BUF_RE, BUF_WE, RX_READY, TX_VALID, BUF_ADDR, TX_DATA[7:0]}, 32'h0);
        tick();

        // Zero-length issue: one FLUSH cycle, no buffer activity
        mark(); RX_VALID = 1'b1;
        issue(9'h033, 6'd0, 2'b01, 2'b01);
        run(10, wcyc);
        RX_VALID = 1'b0;
        chk("zero_wcyc", wcyc, 1);
        chk("zero_nwr", wr_n - wr_base, 0);
        chk("zero_cnt", BLCK_COUNT_SENT, 6'd0);
        chk("zero_ancill", BLCK_ANCILL, {2'b01, 1'b0, 9'h033, 6'd0, 7'h00});
        tick();

        // Issue with an invalid mode is ignored and status is kept
        issue(9'h0AA, 6'd5, 2'b10, 2'b11);
        @(negedge CLK);
        chk("bad_mode_idle", BLCK_WORKING, 1'b0);
        chk("bad_mode_ancill", BLCK_ANCILL, {2'b01, 1'b0, 9'h033, 6'd0, 7'h00});
        MVBLCK_MODE = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
